// File: rtl/board_pkg.sv
// rtl/board_pkg.sv - board geometry, draw FSM states and a constant-scaling helper
package board_pkg;
    localparam int BOARD_COLS = 8;
    localparam int BOARD_ROWS = 8;
    localparam int N_TILES    = 64;
    localparam int TILE_W     = 19;
    localparam int TILE_H     = 14;

    typedef enum logic {
        IDLE = 1'b0,
        DRAW = 1'b1
    } draw_state_e;

    // Multiply a 3-bit col/row by a constant tile size as a shift-add chain.
    function automatic logic [7:0] scale_idx(input logic [2:0] idx, input int k);
        logic [7:0] acc;
        acc = '0;
        for (int b = 0; b < 8; b++) begin
            if (k[b]) acc = acc + (8'(idx) << b);
        end
        return acc;
    endfunction
endpackage

// File: rtl/rr_tile_picker.sv
// rtl/rr_tile_picker.sv - first set pending tile at or above rr_ptr, wrapping 63 -> 0
module rr_tile_picker
    import board_pkg::*;
(
    input  logic [N_TILES-1:0] pending,
    input  logic [5:0]         rr_ptr,
    output logic               found,
    output logic [5:0]         tile
);
    logic [N_TILES-1:0] rotated;
    logic [5:0]         offset;

    always_comb begin
        rotated = '0;
        offset  = '0;
        for (int i = 0; i < N_TILES; i++) begin
            rotated[i] = pending[6'(i) + rr_ptr];
        end
        // Descending scan leaves the lowest set offset, i.e. nearest to rr_ptr.
        for (int i = N_TILES - 1; i >= 0; i--) begin
            if (rotated[i]) offset = 6'(i);
        end
        found = |pending;
        tile  = rr_ptr + offset;
    end
endmodule

// File: rtl/tile_redraw_scheduler.sv
// rtl/tile_redraw_scheduler.sv - dirty-tile tracker and per-tile pixel sweep for the VGA plot port
module tile_redraw_scheduler #(
    parameter int TILE_W    = board_pkg::TILE_W,
    parameter int TILE_H    = board_pkg::TILE_H,
    parameter int INIT_FULL = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] dirty_set,
    input  logic        full_redraw,
    input  logic        pause,
    output logic [5:0]  tile_n,
    output logic [4:0]  x_count,
    output logic [3:0]  y_count,
    output logic [7:0]  x,
    output logic [6:0]  y,
    output logic        plot,
    output logic        tile_done,
    output logic        idle
);
    import board_pkg::*;

    draw_state_e  state, state_next;
    logic [63:0]  pending;
    logic [63:0]  clear_mask;
    logic [5:0]   rr_ptr;
    logic         pick_found;
    logic [5:0]   pick_tile;
    logic         select;
    logic         advance;
    logic         last_px;

    rr_tile_picker u_picker (
        .pending (pending),
        .rr_ptr  (rr_ptr),
        .found   (pick_found),
        .tile    (pick_tile)
    );

    assign last_px = (x_count == 5'(TILE_W - 1)) && (y_count == 4'(TILE_H - 1));

    always_comb begin
        state_next = state;
        select     = 1'b0;
        advance    = 1'b0;
        clear_mask = '0;
        case (state)
            IDLE: begin
                if (!pause && pick_found) begin
                    select                = 1'b1;
                    clear_mask[pick_tile] = 1'b1;
                    state_next            = DRAW;
                end
            end
            DRAW: begin
                if (!pause) begin
                    advance = 1'b1;
                    if (last_px) state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pending   <= {64{INIT_FULL != 0}};
            rr_ptr    <= '0;
            tile_n    <= '0;
            x_count   <= '0;
            y_count   <= '0;
            tile_done <= 1'b0;
        end else begin
            // Sets are ORed after the clear so a re-mark of the selected tile survives.
            pending   <= (pending & ~clear_mask) | dirty_set | {64{full_redraw}};
            tile_done <= advance && last_px;
            if (select) begin
                tile_n  <= pick_tile;
                x_count <= '0;
                y_count <= '0;
            end else if (advance) begin
                if (last_px) begin
                    rr_ptr <= tile_n + 6'd1;
                end else if (x_count == 5'(TILE_W - 1)) begin
                    x_count <= '0;
                    y_count <= y_count + 4'd1;
                end else begin
                    x_count <= x_count + 5'd1;
                end
            end
        end
    end

    assign plot = (state == DRAW) && !pause;
    assign idle = (state == IDLE) && (pending == '0);
    assign x    = scale_idx(tile_n[2:0], TILE_W) + 8'(x_count);
    assign y    = 7'(scale_idx(tile_n[5:3], TILE_H)) + 7'(y_count);
endmodule

// File: tb/tb_tile_redraw_scheduler.sv
// tb/tb_tile_redraw_scheduler.sv - scoreboard bench for tile_redraw_scheduler
module tb_tile_redraw_scheduler;
    localparam int TW   = 19;
    localparam int TH   = 14;
    localparam int NPIX = TW * TH;
    localparam int TCYC = NPIX + 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset0, full0, pause0;
    logic [63:0] dirty0;
    logic [5:0]  tile_n0;
    logic [4:0]  xc0;
    logic [3:0]  yc0;
    logic [7:0]  x0;
    logic [6:0]  y0;
    logic        plot0, done0, idle0;

    logic        reset1, full1, pause1;
    logic [63:0] dirty1;
    logic [5:0]  tile_n1;
    logic [4:0]  xc1;
    logic [3:0]  yc1;
    logic [7:0]  x1;
    logic [6:0]  y1;
    logic        plot1, done1, idle1;

    tile_redraw_scheduler #(.TILE_W(TW), .TILE_H(TH), .INIT_FULL(0)) dut0 (
        .clk(clk), .reset(reset0), .dirty_set(dirty0), .full_redraw(full0), .pause(pause0),
        .tile_n(tile_n0), .x_count(xc0), .y_count(yc0), .x(x0), .y(y0),
        .plot(plot0), .tile_done(done0), .idle(idle0)
    );

    tile_redraw_scheduler #(.TILE_W(TW), .TILE_H(TH), .INIT_FULL(1)) dut1 (
        .clk(clk), .reset(reset1), .dirty_set(dirty1), .full_redraw(full1), .pause(pause1),
        .tile_n(tile_n1), .x_count(xc1), .y_count(yc1), .x(x1), .y(y1),
        .plot(plot1), .tile_done(done1), .idle(idle1)
    );

    int n_cmp = 0;
    int n_bad = 0;
    logic [5:0] exp_q[$];

    int         mon_px = 0;
    bit         mon_in = 1'b0;
    logic [5:0] mon_tile = '0;
    int         ex_x, ex_y, ex_xc, ex_yc;

    // Scoreboard monitor: each tile's pixels are predicted from the queued tile number.
    always @(negedge clk) begin
        if (reset0) begin
            mon_in = 1'b0;
            mon_px = 0;
        end else begin
            if (plot0) begin
                if (!mon_in) begin
                    n_cmp++;
                    if (exp_q.size() == 0) begin
                        n_bad++;
                        $display("FAIL sb_tile unexpected tile got=%0d want=none", tile_n0);
                        mon_tile = tile_n0;
                    end else begin
                        mon_tile = exp_q.pop_front();
                        if (tile_n0 !== mon_tile) begin
                            n_bad++;
                            $display("FAIL sb_tile got=%0d want=%0d", tile_n0, mon_tile);
                        end
                    end
                    mon_in = 1'b1;
                    mon_px = 0;
                end
                ex_xc = mon_px % TW;
                ex_yc = mon_px / TW;
                ex_x  = int'(mon_tile[2:0]) * TW + ex_xc;
                ex_y  = int'(mon_tile[5:3]) * TH + ex_yc;
                n_cmp++;
                if ({tile_n0, xc0, yc0, x0, y0} !== {mon_tile, 5'(ex_xc), 4'(ex_yc), 8'(ex_x), 7'(ex_y)}) begin
                    n_bad++;
                    $display("FAIL sb_pixel tile=%0d px=%0d got xc=%0d yc=%0d x=%0d y=%0d want xc=%0d yc=%0d x=%0d y=%0d",
                             mon_tile, mon_px, xc0, yc0, x0, y0, ex_xc, ex_yc, ex_x, ex_y);
                end
                mon_px++;
            end
            if (done0) begin
                n_cmp++;
                if (!mon_in || mon_px != NPIX) begin
                    n_bad++;
                    $display("FAIL sb_pixel_count got=%0d want=%0d", mon_px, NPIX);
                end
                mon_in = 1'b0;
            end
        end
    end

    task automatic wait_done0(input int budget, output bit ok, output logic [7:0] lx, output logic [6:0] ly);
        ok = 1'b0;
        lx = '0;
        ly = '0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (plot0) begin
                lx = x0;
                ly = y0;
            end
            if (done0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset0 = 1'b1; dirty0 = '0; full0 = 1'b0; pause0 = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({plot0, done0, idle0} !== 3'b001) begin
            n_bad++; $display("FAIL reset_flags got plot/done/idle=%b want=001", {plot0, done0, idle0});
        end
        n_cmp++;
        if ({tile_n0, xc0, yc0, x0, y0} !== 30'd0) begin
            n_bad++; $display("FAIL reset_counters got tile=%0d x=%0d y=%0d want 0", tile_n0, x0, y0);
        end
        @(posedge clk); #1 reset0 = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({plot0, idle0} !== 2'b01) begin
            n_bad++; $display("FAIL reset_release got plot/idle=%b want=01", {plot0, idle0});
        end
    endtask

    task automatic test_single_tile();
        bit ok; logic [7:0] lx; logic [6:0] ly;
        @(negedge clk); dirty0 = 64'd1 << 9; exp_q.push_back(6'd9);
        @(negedge clk); dirty0 = '0;
        n_cmp++;
        if (plot0 !== 1'b0) begin n_bad++; $display("FAIL latency_early got plot=%b want=0", plot0); end
        @(negedge clk);
        n_cmp++;
        if ({plot0, x0, y0} !== {1'b1, 8'd19, 7'd14}) begin
            n_bad++; $display("FAIL first_pixel got plot=%b x=%0d y=%0d want 1 19 14", plot0, x0, y0);
        end
        wait_done0(400, ok, lx, ly);
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL single_done got=timeout want=tile_done"); end
        n_cmp++;
        if ({lx, ly} !== {8'd37, 7'd27}) begin
            n_bad++; $display("FAIL single_last got x=%0d y=%0d want 37 27", lx, ly);
        end
        @(negedge clk);
        n_cmp++;
        if ({idle0, plot0, done0} !== 3'b100) begin
            n_bad++; $display("FAIL single_idle got idle/plot/done=%b want=100", {idle0, plot0, done0});
        end
    endtask

    task automatic test_round_robin();
        bit ok; logic [7:0] lx; logic [6:0] ly;
        @(negedge clk);
        dirty0 = (64'd1 << 3) | (64'd1 << 12);
        exp_q.push_back(6'd12);
        exp_q.push_back(6'd3);
        @(negedge clk); dirty0 = '0;
        wait_done0(400, ok, lx, ly);
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL rr_first_done got=timeout want=tile_done"); end
        @(negedge clk);
        n_cmp++;
        if ({plot0, tile_n0} !== {1'b1, 6'd3}) begin
            n_bad++; $display("FAIL back_to_back got plot=%b tile=%0d want 1 3", plot0, tile_n0);
        end
        wait_done0(400, ok, lx, ly);
        n_cmp++;
        if (!ok || exp_q.size() != 0) begin
            n_bad++; $display("FAIL rr_second_done got ok=%b queued=%0d want 1 0", ok, exp_q.size());
        end
    endtask

    task automatic test_pause();
        bit ok, found; logic [7:0] lx; logic [6:0] ly;
        @(negedge clk); dirty0 = 64'd1 << 20; exp_q.push_back(6'd20);
        @(negedge clk); dirty0 = '0;
        found = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (plot0 && xc0 == 5'd6 && yc0 == 4'd2) begin found = 1'b1; break; end
        end
        n_cmp++;
        if (!found) begin n_bad++; $display("FAIL pause_reach got=timeout want=x6y2"); end
        @(posedge clk); #1 pause0 = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            n_cmp++;
            if ({plot0, xc0, yc0} !== {1'b0, 5'd7, 4'd2}) begin
                n_bad++; $display("FAIL pause_hold cyc=%0d got plot=%b xc=%0d yc=%0d want 0 7 2", k, plot0, xc0, yc0);
            end
        end
        @(posedge clk); #1 pause0 = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({plot0, xc0, yc0} !== {1'b1, 5'd7, 4'd2}) begin
            n_bad++; $display("FAIL pause_resume got plot=%b xc=%0d yc=%0d want 1 7 2", plot0, xc0, yc0);
        end
        wait_done0(400, ok, lx, ly);
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL pause_done got=timeout want=tile_done"); end
    endtask

    task automatic test_remark();
        bit ok, found; logic [7:0] lx; logic [6:0] ly;
        @(negedge clk); dirty0 = 64'd1 << 5; exp_q.push_back(6'd5);
        @(negedge clk); dirty0 = '0;
        found = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (plot0 && xc0 == 5'd5 && yc0 == 4'd5) begin found = 1'b1; break; end
        end
        n_cmp++;
        if (!found) begin n_bad++; $display("FAIL remark_reach got=timeout want=pixel100"); end
        dirty0 = 64'd1 << 5; exp_q.push_back(6'd5);
        @(negedge clk); dirty0 = '0;
        wait_done0(400, ok, lx, ly);
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL remark_first_done got=timeout want=tile_done"); end
        @(negedge clk);
        n_cmp++;
        if ({plot0, tile_n0, xc0, yc0} !== {1'b1, 6'd5, 5'd0, 4'd0}) begin
            n_bad++; $display("FAIL remark_redraw got plot=%b tile=%0d xc=%0d yc=%0d want 1 5 0 0", plot0, tile_n0, xc0, yc0);
        end
        wait_done0(400, ok, lx, ly);
        @(negedge clk);
        n_cmp++;
        if (!ok || idle0 !== 1'b1) begin
            n_bad++; $display("FAIL remark_idle got ok=%b idle=%b want 1 1", ok, idle0);
        end
    endtask

    task automatic test_full_redraw();
        bit ok; int dones; logic [7:0] lx; logic [6:0] ly;
        @(negedge clk); dirty0 = 64'd1 << 63; exp_q.push_back(6'd63);
        @(negedge clk); dirty0 = '0;
        @(negedge clk);
        n_cmp++;
        if ({plot0, tile_n0} !== {1'b1, 6'd63}) begin
            n_bad++; $display("FAIL full_start got plot=%b tile=%0d want 1 63", plot0, tile_n0);
        end
        full0 = 1'b1;
        for (int t = 0; t < 64; t++) exp_q.push_back(6'(t));
        @(negedge clk); full0 = 1'b0;
        wait_done0(400, ok, lx, ly);
        n_cmp++;
        if (!ok || {lx, ly} !== {8'd151, 7'd111}) begin
            n_bad++; $display("FAIL full_last63 got ok=%b x=%0d y=%0d want 1 151 111", ok, lx, ly);
        end
        dones = 0;
        for (int t = 0; t < 64; t++) begin
            wait_done0(TCYC + 10, ok, lx, ly);
            if (!ok) break;
            dones++;
        end
        @(negedge clk);
        n_cmp++;
        if (dones != 64 || idle0 !== 1'b1 || exp_q.size() != 0) begin
            n_bad++; $display("FAIL full_board got dones=%0d idle=%b queued=%0d want 64 1 0", dones, idle0, exp_q.size());
        end
    endtask

    task automatic test_reset_mid_draw();
        int dones, plots, order_bad;
        n_cmp++;
        if ({idle1, plot1} !== 2'b00) begin
            n_bad++; $display("FAIL init_full_reset got idle/plot=%b want=00", {idle1, plot1});
        end
        @(posedge clk); #1 reset1 = 1'b0;
        repeat (50) @(negedge clk);
        n_cmp++;
        if ({plot1, tile_n1} !== {1'b1, 6'd0}) begin
            n_bad++; $display("FAIL mid_draw got plot=%b tile=%0d want 1 0", plot1, tile_n1);
        end
        @(posedge clk); #1 reset1 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({plot1, tile_n1, x1, y1} !== 22'd0) begin
            n_bad++; $display("FAIL mid_reset got plot=%b tile=%0d x=%0d y=%0d want 0", plot1, tile_n1, x1, y1);
        end
        reset1 = 1'b0;
        dones = 0; plots = 0; order_bad = 0;
        for (int c = 0; c <= 64 * TCYC; c++) begin
            if (c > 0) @(negedge clk);
            if (plot1) plots++;
            if (done1) begin
                if (tile_n1 !== 6'(dones) || c != TCYC * (dones + 1)) order_bad++;
                dones++;
            end
            if (c == 64 * TCYC - 1) begin
                n_cmp++;
                if (idle1 !== 1'b0) begin n_bad++; $display("FAIL idle_early got=%b want=0", idle1); end
            end
        end
        n_cmp++;
        if (idle1 !== 1'b1) begin n_bad++; $display("FAIL idle_after_board got=%b want=1", idle1); end
        n_cmp++;
        if (dones != 64 || plots != 64 * NPIX || order_bad != 0) begin
            n_bad++; $display("FAIL board_order got dones=%0d plots=%0d bad=%0d want 64 %0d 0", dones, plots, order_bad, 64 * NPIX);
        end
    endtask

    initial begin
        reset1 = 1'b1; dirty1 = '0; full1 = 1'b0; pause1 = 1'b0;
        test_reset();
        test_single_tile();
        test_round_robin();
        test_pause();
        test_remark();
        test_full_redraw();
        test_reset_mid_draw();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/tile_redraw_scheduler.md
Name: tile_redraw_scheduler

Overview:
- Owns the VGA plot port for the 8x8 minesweeper board.
- Tracks which tiles are dirty because their mine/flag/step/position status changed.
- Sequences one 19x14-pixel sweep per dirty tile, emitting tile_n, the in-tile pixel counters and the screen x/y with a plot strobe. The existing tile_report/pixel_color path consumes these to produce colour.
- Round-robin selection across dirty tiles keeps a burst of updates in low tile numbers from starving other tiles.

Parameters:
- TILE_W, 19, pixels per tile horizontally (x_count range 0..TILE_W-1)
- TILE_H, 14, pixels per tile vertically (y_count range 0..TILE_H-1)
- INIT_FULL, 1, when 1 the pending mask resets to all ones, so the whole board is drawn after reset

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- dirty_set  in  64  per-tile mark-dirty pulses; bit i marks tile i
- full_redraw  in  1  pulse; marks all 64 tiles dirty
- pause  in  1  VGA port lent elsewhere; hold the sweep
- tile_n  out  6  tile being drawn (col = [2:0], row = [5:3])
- x_count  out  5  pixel column within tile
- y_count  out  4  pixel row within tile
- x  out  8  screen x = col*TILE_W + x_count
- y  out  7  screen y = row*TILE_H + y_count
- plot  out  1  pixel valid this cycle
- tile_done  out  1  one-cycle pulse after a tile's last pixel
- idle  out  1  state IDLE and pending mask is zero

Behaviour:
- State: 64-bit pending mask, 6-bit rr_ptr, tile_n, x_count, y_count, FSM {IDLE, DRAW}.
- Reset values:
  - pending = INIT_FULL ? all ones : 0; rr_ptr = 0; state = IDLE.
  - tile_n = x_count = y_count = x = y = 0; plot = 0; tile_done = 0; idle = !INIT_FULL.
- Pending update, every cycle: pending_next = (pending & ~clear_mask) | dirty_set | {64{full_redraw}}. A set wins over a clear on the same bit in the same cycle.
- IDLE, pause = 0, pending != 0:
  - Pick the first set bit scanning upward from rr_ptr, wrapping 63 -> 0.
  - Register it into tile_n and clear that pending bit (clear_mask).
  - Set x_count = y_count = 0 and go to DRAW.
- IDLE with pause = 1 or pending = 0: stay, plot = 0.
- DRAW, pause = 0:
  - plot = 1; x/y/x_count/y_count/tile_n are registered and aligned with plot.
  - Advance x_count. When x_count = TILE_W-1, wrap to 0 and increment y_count.
  - The pixel with x_count = TILE_W-1 and y_count = TILE_H-1 is the last pixel. The cycle after it: tile_done = 1, plot = 0, rr_ptr = tile_n+1 (mod 64), state = IDLE.
- DRAW, pause = 1: counters and outputs hold, plot = 0 (pixel not emitted). The sweep resumes at the same pixel when pause drops.
- One tile costs TILE_W*TILE_H = 266 plot cycles plus 1 IDLE select cycle. Back-to-back tiles are therefore separated by exactly one non-plot cycle.
- Latency: dirty_set pulse at cycle t with FSM in IDLE and no pause -> pending at t+1 -> DRAW selected at t+1 -> first plot = 1 at cycle t+2.
- A dirty_set on the tile currently in DRAW re-queues it; the bit was cleared at selection. It is redrawn later in round-robin order.
- Width rules:
  - x = col*19 + x_count; max 151, fits 8 bits.
  - y = row*14 + y_count; max 111, fits 7 bits.
  - Compute with shifts/adds, no multiplier.
- Reset asserted mid-DRAW: next cycle all registers take reset values. A partially drawn tile is not resumed unless re-marked (INIT_FULL=1 re-marks it).
- full_redraw during DRAW: all bits, including the current tile, are pending after this tile finishes.

Decomposition:
- Shared package board_pkg:
  - BOARD_COLS = 8, BOARD_ROWS = 8, N_TILES = 64, TILE_W = 19, TILE_H = 14.
  - FSM state enum {IDLE, DRAW}.
- Sub-module rr_tile_picker: combinational 64-bit round-robin priority encoder.
  - Inputs: pending[63:0], rr_ptr[5:0].
  - Outputs: found, tile[5:0].

Test Plan:
- INIT_FULL=0, reset, dirty_set bit 9 (col 1, row 1) -> plot first high 2 cycles later with x=19, y=14, and 266 plot cycles ending at x=37, y=27; then tile_done pulse; then idle = 1.
- Round-robin: after tile 9 is drawn, set bits 3 and 12 together -> tile 12 is drawn before tile 3 (rr_ptr = 10).
- pause asserted for 5 cycles mid-sweep at x_count=7, y_count=2 -> plot = 0 and counters frozen; resume at 7,2; total plot count stays 266.
- Re-mark the current tile at pixel 100 of tile 5, no other pending -> tile_done, 1 IDLE cycle, then tile 5 drawn again in full.
- Reset asserted mid-DRAW -> next cycle plot = 0 and tile_n = 0. With INIT_FULL=1, tiles 0..63 then drawn in order, 64 tile_done pulses, and idle high after 64*267 cycles.
- full_redraw while drawing tile 63 (col 7, row 7) -> its last pixel is x=151, y=111; then wrap, with tiles 0..63 redrawn starting at 0.
